// File: rtl/zir_capture_sequencer.sv
// zir_capture_sequencer: power-up delay, N-frame capture burst, Wr_Done handshake and upload re-arm,
// with frame watchdog, burst counter and a free-running simulated pixel clock.
module zir_capture_sequencer #(
    parameter int POR_DELAY_CYC     = 48000000,
    parameter int FRAMES_PER_BURST  = 2,
    parameter int DONE_PULSE_CYC    = 6,
    parameter int FRAME_TIMEOUT_CYC = 4800000,
    parameter int PCLK_DIV          = 5
) (
    input  logic                                  clk_48MHz_Global,
    input  logic                                  rst_n,
    input  logic                                  iContinuous,
    input  logic                                  iWr_Frame_Done,
    input  logic                                  iUpload_Done,
    output logic                                  oCapture_En,
    output logic                                  oDDRWriter_En,
    output logic                                  oWr_Done,
    output logic                                  oTimeout,
    output logic [15:0]                           oBurst_Cnt,
    output logic [$clog2(FRAMES_PER_BURST+1)-1:0] oFrame_Idx,
    output logic                                  oPCLK_Sim
);
    localparam int POR_W = POR_DELAY_CYC > 1 ? $clog2(POR_DELAY_CYC) : 1;
    localparam int WD_W  = FRAME_TIMEOUT_CYC > 1 ? $clog2(FRAME_TIMEOUT_CYC) : 1;
    localparam int DN_W  = DONE_PULSE_CYC > 1 ? $clog2(DONE_PULSE_CYC) : 1;
    localparam int PD_W  = PCLK_DIV > 1 ? $clog2(PCLK_DIV) : 1;
    localparam int FI_W  = $clog2(FRAMES_PER_BURST + 1);
    localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_DELAY_CYC - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(FRAME_TIMEOUT_CYC == 0 ? 0 : FRAME_TIMEOUT_CYC - 1);
    localparam logic [DN_W-1:0]  DN_LAST  = DN_W'(DONE_PULSE_CYC - 1);
    localparam logic [PD_W-1:0]  PD_LAST  = PD_W'(PCLK_DIV - 1);
    localparam logic [FI_W-1:0]  FI_LAST  = FI_W'(FRAMES_PER_BURST - 1);
    localparam logic             WD_ON    = FRAME_TIMEOUT_CYC != 0;

    typedef enum logic [1:0] {S_POR, S_CAPT, S_DONE, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [POR_W-1:0]  por_q, por_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [DN_W-1:0]   done_q, done_d;
    logic [PD_W-1:0]   pdiv_q, pdiv_d;
    logic [FI_W-1:0]   idx_q, idx_d;
    logic [15:0]       burst_q, burst_d;
    logic              tmo_q, tmo_d, pclk_q, pclk_d;
    logic              frame_prev_q, upl_prev_q;
    logic              frame_evt, upl_evt;

    assign frame_evt = iWr_Frame_Done & ~frame_prev_q;
    assign upl_evt   = iUpload_Done & ~upl_prev_q;

    always_comb begin
        state_d = state_q;
        por_d   = por_q;
        wd_d    = '0;
        done_d  = '0;
        idx_d   = idx_q;
        burst_d = burst_q;
        tmo_d   = tmo_q;
        pdiv_d  = pdiv_q == PD_LAST ? '0 : pdiv_q + 1'b1;
        pclk_d  = pclk_q ^ (pdiv_q == PD_LAST);
        case (state_q)
            S_POR: begin
                if (por_q == POR_LAST) state_d = S_CAPT;
                else por_d = por_q + 1'b1;
            end
            S_CAPT: begin
                // a frame edge takes priority over a simultaneous watchdog expiry
                if (frame_evt) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == FI_LAST) state_d = S_DONE;
                end else if (WD_ON && wd_q == WD_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DONE: begin
                if (done_q == DN_LAST) begin
                    state_d = S_WAIT;
                    burst_d = burst_q + 1'b1;
                end else begin
                    done_d = done_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (upl_evt && iContinuous) begin
                    idx_d   = '0;
                    tmo_d   = 1'b0;
                    state_d = S_CAPT;
                end
            end
            default: state_d = S_POR;
        endcase
    end

    always_ff @(posedge clk_48MHz_Global or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_POR;
            por_q        <= '0;
            wd_q         <= '0;
            done_q       <= '0;
            pdiv_q       <= '0;
            idx_q        <= '0;
            burst_q      <= '0;
            tmo_q        <= 1'b0;
            pclk_q       <= 1'b0;
            frame_prev_q <= 1'b0;
            upl_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            por_q        <= por_d;
            wd_q         <= wd_d;
            done_q       <= done_d;
            pdiv_q       <= pdiv_d;
            idx_q        <= idx_d;
            burst_q      <= burst_d;
            tmo_q        <= tmo_d;
            pclk_q       <= pclk_d;
            frame_prev_q <= iWr_Frame_Done;
            upl_prev_q   <= iUpload_Done;
        end
    end

    assign oCapture_En   = state_q == S_CAPT;
    assign oDDRWriter_En = state_q == S_CAPT;
    assign oWr_Done      = state_q == S_DONE;
    assign oTimeout      = tmo_q;
    assign oBurst_Cnt    = burst_q;
    assign oFrame_Idx    = idx_q;
    assign oPCLK_Sim     = pclk_q;
endmodule

// File: tb/tb_zir_capture_sequencer.sv
// tb_zir_capture_sequencer: scenario tasks plus a Wr_Done scoreboard monitor for zir_capture_sequencer.
module tb_zir_capture_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cont = 1'b0, frame = 1'b0, upload = 1'b0;
    logic en_cap, en_ddr, wr_done, tmo, pclk;
    logic [15:0] burst;
    logic [1:0] idx;

    typedef struct packed {logic [15:0] burst; logic [1:0] idx;} exp_t;
    exp_t sb[$];
    exp_t e_mon;
    int errors = 0, checks = 0, wlen = 0, done_seen = 0;

    always #5 clk = ~clk;

    zir_capture_sequencer #(
        .POR_DELAY_CYC(100), .FRAMES_PER_BURST(2), .DONE_PULSE_CYC(6),
        .FRAME_TIMEOUT_CYC(500), .PCLK_DIV(5)
    ) dut (
        .clk_48MHz_Global(clk), .rst_n(rst_n), .iContinuous(cont),
        .iWr_Frame_Done(frame), .iUpload_Done(upload),
        .oCapture_En(en_cap), .oDDRWriter_En(en_ddr), .oWr_Done(wr_done),
        .oTimeout(tmo), .oBurst_Cnt(burst), .oFrame_Idx(idx), .oPCLK_Sim(pclk)
    );

    // Each completed Wr_Done pulse consumes one expected burst record.
    always @(negedge clk) begin
        if (wr_done === 1'b1) begin
            wlen++;
        end else if (wlen != 0) begin
            checks++;
            if (wlen != 6) begin
                errors++;
                $display("FAIL wr_done_width: got %0d clk, expected 6", wlen);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wr_done_unexpected: pulse with nothing expected (burst=%0d)", burst);
            end else begin
                e_mon = sb.pop_front();
                if ({burst, idx} !== {e_mon.burst, e_mon.idx}) begin
                    errors++;
                    $display("FAIL burst_result: got cnt=%0d idx=%0d, expected cnt=%0d idx=%0d",
                             burst, idx, e_mon.burst, e_mon.idx);
                end
            end
            wlen = 0;
            done_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
    endtask

    task automatic pulse_upload();
        upload = 1'b1;
        @(negedge clk);
        upload = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        tick(3);
        checks++;
        if ({en_cap, en_ddr, wr_done, tmo, burst, idx, pclk} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {en_cap, en_ddr, wr_done, tmo, burst, idx, pclk});
        end
        rst_n = 1'b1;
        n = 0;
        while (en_cap !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 100 || en_ddr !== 1'b1) begin
            errors++;
            $display("FAIL por_delay: enables after %0d clk (ddr=%b), expected 100 (ddr=1)", n, en_ddr);
        end
    endtask

    task automatic test_pclk();
        int n = 0, hi = 0, lo = 0;
        while (pclk !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        while (pclk !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        while (pclk === 1'b1 && n < 50) begin @(negedge clk); n++; hi++; end
        while (pclk === 1'b0 && n < 50) begin @(negedge clk); n++; lo++; end
        checks++;
        if (hi != 5 || lo != 5) begin
            errors++;
            $display("FAIL pclk_period: got high=%0d low=%0d, expected 5/5", hi, lo);
        end
    endtask

    task automatic test_burst();
        pulse_frame();
        checks++;
        if (idx !== 2'd1) begin
            errors++;
            $display("FAIL frame_idx_1: got %0d, expected 1", idx);
        end
        tick(49);
        checks++;
        if ({en_cap, en_ddr} !== 2'b11) begin
            errors++;
            $display("FAIL enables_hold: got %b, expected 11", {en_cap, en_ddr});
        end
        sb.push_back({16'd1, 2'd2});
        pulse_frame();
        checks++;
        if ({en_cap, en_ddr, wr_done} !== 3'b001) begin
            errors++;
            $display("FAIL burst_end: got cap/ddr/done=%b, expected 001", {en_cap, en_ddr, wr_done});
        end
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL burst1_done: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_continuous();
        cont = 1'b1;
        pulse_upload();
        checks++;
        if ({en_cap, en_ddr, idx} !== 4'b1100) begin
            errors++;
            $display("FAIL rearm: got cap/ddr/idx=%b, expected 1100", {en_cap, en_ddr, idx});
        end
        pulse_upload();
        checks++;
        if ({en_cap, idx, tmo} !== 4'b1000) begin
            errors++;
            $display("FAIL upload_in_capt: got cap/idx/tmo=%b, expected 1000", {en_cap, idx, tmo});
        end
        pulse_frame();
        tick(10);
        sb.push_back({16'd2, 2'd2});
        pulse_frame();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0 || burst !== 16'd2) begin
            errors++;
            $display("FAIL burst2_done: outstanding=%0d cnt=%0d, expected 0 and 2", sb.size(), burst);
        end
        pulse_frame();
        tick(2);
        checks++;
        if ({en_cap, idx} !== 3'b010) begin
            errors++;
            $display("FAIL frame_in_wait: got cap/idx=%b, expected 010", {en_cap, idx});
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        pulse_upload();
        while (en_cap === 1'b1 && n < 700) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 500) begin
            errors++;
            $display("FAIL watchdog_len: enables high %0d clk, expected 500", n);
        end
        checks++;
        if ({tmo, en_ddr} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_flag: got tmo/ddr=%b, expected 10", {tmo, en_ddr});
        end
        tick(20);
        checks++;
        if ({wr_done, burst, tmo} !== {1'b0, 16'd2, 1'b1}) begin
            errors++;
            $display("FAIL timeout_no_done: got done=%b cnt=%0d tmo=%b, expected 0/2/1", wr_done, burst, tmo);
        end
        pulse_upload();
        checks++;
        if ({tmo, en_cap, idx} !== 4'b0100) begin
            errors++;
            $display("FAIL timeout_clear: got tmo/cap/idx=%b, expected 0100", {tmo, en_cap, idx});
        end
        pulse_frame();
        tick(5);
        sb.push_back({16'd3, 2'd2});
        pulse_frame();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL burst3_done: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_single();
        int high = 0;
        cont = 1'b0;
        pulse_upload();
        repeat (2000) begin
            @(negedge clk);
            if (en_cap !== 1'b0 || en_ddr !== 1'b0) high++;
        end
        checks++;
        if (high != 0) begin
            errors++;
            $display("FAIL single_shot: enables high %0d clk, expected 0", high);
        end
        pulse_upload();
        cont = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (en_cap !== 1'b0 || en_ddr !== 1'b0) high++;
        end
        checks++;
        if (high != 0 || {idx, burst} !== {2'd2, 16'd3}) begin
            errors++;
            $display("FAIL single_second: high=%0d idx=%0d cnt=%0d, expected 0/2/3", high, idx, burst);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        while (en_cap !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (n != 100) begin
            errors++;
            $display("FAIL por_after_reset: enables after %0d clk, expected 100", n);
        end
        frame = 1'b1;
        tick(20);
        frame = 1'b0;
        tick(3);
        checks++;
        if ({en_cap, idx} !== 3'b101) begin
            errors++;
            $display("FAIL level_frame: got cap/idx=%b, expected 101", {en_cap, idx});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({en_cap, en_ddr, wr_done, tmo, burst, idx, pclk} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b, expected all zero",
                     {en_cap, en_ddr, wr_done, tmo, burst, idx, pclk});
        end
        tick(3);
        rst_n = 1'b1;
        n = 0;
        while (en_cap !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (n != 100) begin
            errors++;
            $display("FAIL por_repeat: enables after %0d clk, expected 100", n);
        end
        checks++;
        if (sb.size() != 0 || done_seen != 3) begin
            errors++;
            $display("FAIL scoreboard_end: outstanding=%0d pulses=%0d, expected 0 and 3", sb.size(), done_seen);
        end
    endtask

    initial begin
        test_reset();
        test_pclk();
        test_burst();
        test_continuous();
        test_timeout();
        test_single();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
